aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Control FSM that sequences an iterative AES encryption datapath: one round per clock, sharing a single round engine across AES-128/192/256.
- Accepts a block request over a valid/ready handshake, optionally triggers key expansion, then steps the round index from 0 to Nr.
- Presents the result over a valid/ready handshake.
- Sits between the host interface and the round/key-expansion datapath; performs no data manipulation.

Parameters:
KEXP_TIMEOUT, 64, max cycles to wait for key_exp_done before flagging an error (range 1..255)
CNT_W, 16, width of the completed-block counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host requests encryption of the block currently on the datapath input
req_ready  out  1  sequencer can accept a request
key_len  in  2  0=128 (Nr=10), 1=192 (Nr=12), 2=256 (Nr=14), 3=illegal; sampled on accept
key_reuse  in  1  skip key expansion; sampled on accept; honoured only if a prior expansion with the same key_len completed
abort  in  1  synchronous abort; returns to IDLE
key_exp_start  out  1  one-cycle pulse starting key expansion
key_exp_done  in  1  key expansion complete (level or pulse)
ld_state  out  1  load input block XOR round key 0
round_en  out  1  apply one round this cycle
round_idx  out  4  round-key index for current datapath operation
last_round  out  1  final round (no MixColumns)
out_valid  out  1  result held on datapath output
out_ready  in  1  consumer accepts result
err  out  1  one-cycle pulse: illegal key_len or key-expansion timeout
busy  out  1  high in every state except IDLE
blk_cnt  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: req_ready=1, all strobes 0, round_idx=0, err=0, blk_cnt=0. Cached key_len is invalid.
- States: IDLE, KEXP, INIT, ROUND, FINAL, DONE.
- IDLE: req_ready=1. Accept = req_valid & req_ready.
  - Accept with key_len=3: err=1 next cycle; stay IDLE.
  - Accept with key_reuse=1 and cache valid with equal key_len: go to INIT.
  - Any other accept: go to KEXP and latch Nr.
- KEXP: key_exp_start=1 on the first KEXP cycle only. Wait for key_exp_done.
  - key_exp_done seen: cache key_len (valid=1); go to INIT.
  - No key_exp_done within KEXP_TIMEOUT cycles (counted from the start pulse): err pulse, invalidate cache, go to IDLE.
- INIT: one cycle; ld_state=1, round_idx=0; go to ROUND.
- ROUND: round_en=1, round_idx increments 1..Nr-1, one cycle each. After idx Nr-1, go to FINAL.
- FINAL: one cycle; round_en=1, last_round=1, round_idx=Nr; go to DONE.
- DONE: out_valid=1, held stable until out_ready=1. On the handshake: blk_cnt++ (wraps modulo 2^CNT_W); go to IDLE. out_ready with out_valid=0 has no effect.
- Latency (reuse path), accept at cycle 0: INIT at cycle 1, round k at cycle k+1, FINAL at cycle Nr+1, out_valid at cycle Nr+2 (12/14/16 for 128/192/256).
- Strobe encoding: ld_state, round_en and key_exp_start are mutually exclusive; last_round is only ever asserted with round_en; all strobes are registered (no combinational path from inputs).
- abort:
  - Has priority over every transition. From any state, next cycle state=IDLE, strobes 0, no out_valid, blk_cnt unchanged.
  - Abort during KEXP invalidates the cache.
  - Abort in the same cycle as req_valid in IDLE: request is not accepted.
- key_len and key_reuse changes after accept are ignored until the next IDLE.

Test Plan:
- key_len=0, key_reuse=0, key_exp_done 5 cycles after start → key_exp_start pulses once; ld_state then round_idx 1..9; last_round with idx 10; out_valid held until out_ready; blk_cnt=1.
- Back-to-back key_len=2 with key_reuse=1 after a completed expansion → no key_exp_start; out_valid exactly 16 cycles after accept; idx sequence 0..14.
- key_len=1, reuse=1 after a 256-bit expansion → full KEXP path taken (cache mismatch); 12 rounds, last_round at idx 12.
- key_len=3 → err pulse one cycle; req_ready stays 1; busy stays 0; no strobes.
- key_exp_done withheld, KEXP_TIMEOUT=64 → err exactly 64 cycles after key_exp_start; state IDLE; subsequent reuse request re-expands.
- abort at round_idx=5, and separately in DONE with out_ready=0 → IDLE next cycle, out_valid never asserts, blk_cnt unchanged; async rst_n mid-ROUND clears all outputs immediately.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES datapath: accepts a block, optionally runs
// key expansion, then steps one round per clock and hands the result off.
module aes_round_sequencer #(
  parameter int KEXP_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       key_len,
  input  logic             key_reuse,
  input  logic             abort,
  output logic             key_exp_start,
  input  logic             key_exp_done,
  output logic             ld_state,
  output logic             round_en,
  output logic [3:0]       round_idx,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(KEXP_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       nr_q, nr_d;
  logic [1:0]       len_q, len_d;
  logic [7:0]       kexp_cnt_q, kexp_cnt_d;
  logic             cache_valid_q, cache_valid_d;
  logic [1:0]       cache_len_q, cache_len_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [3:0]       round_idx_q, round_idx_d;
  logic             req_ready_q, req_ready_d;
  logic             key_exp_start_q, key_exp_start_d;
  logic             ld_state_q, ld_state_d;
  logic             round_en_q, round_en_d;
  logic             last_round_q, last_round_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             reuse_hit;

  assign accept    = req_valid & req_ready_q;
  assign reuse_hit = key_reuse & cache_valid_q & (cache_len_q == key_len);

  always_comb begin
    state_d       = state_q;
    nr_d          = nr_q;
    len_d         = len_q;
    kexp_cnt_d    = '0;
    cache_valid_d = cache_valid_q;
    cache_len_d   = cache_len_q;
    blk_cnt_d     = blk_cnt_q;
    err_d         = 1'b0;

    if (abort) begin
      state_d = IDLE;
      if (state_q == KEXP) cache_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (key_len == 2'd3) begin
              err_d = 1'b1;
            end else begin
              nr_d    = 4'd10 + {1'b0, key_len, 1'b0};
              len_d   = key_len;
              state_d = reuse_hit ? INIT : KEXP;
            end
          end
        end
        KEXP: begin
          // The counter starts at zero on the start-pulse cycle
          if (key_exp_done) begin
            cache_valid_d = 1'b1;
            cache_len_d   = len_q;
            state_d       = INIT;
          end else if (kexp_cnt_q == TIMEOUT_LAST) begin
            err_d         = 1'b1;
            cache_valid_d = 1'b0;
            state_d       = IDLE;
          end else begin
            kexp_cnt_d = kexp_cnt_q + 8'd1;
          end
        end
        INIT:  state_d = ROUND;
        ROUND: if (round_idx_q == nr_q - 4'd1) state_d = FINAL;
        FINAL: state_d = DONE;
        DONE: begin
          if (out_ready) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop
    round_idx_d = '0;
    case (state_d)
      ROUND:   round_idx_d = (state_q == ROUND) ? round_idx_q + 4'd1 : 4'd1;
      FINAL:   round_idx_d = nr_q;
      default: round_idx_d = '0;
    endcase
    req_ready_d     = (state_d == IDLE);
    busy_d          = (state_d != IDLE);
    key_exp_start_d = (state_d == KEXP) && (state_q != KEXP);
    ld_state_d      = (state_d == INIT);
    round_en_d      = (state_d == ROUND) || (state_d == FINAL);
    last_round_d    = (state_d == FINAL);
    out_valid_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      nr_q            <= 4'd10;
      len_q           <= '0;
      kexp_cnt_q      <= '0;
      cache_valid_q   <= 1'b0;
      cache_len_q     <= '0;
      blk_cnt_q       <= '0;
      round_idx_q     <= '0;
      req_ready_q     <= 1'b1;
      key_exp_start_q <= 1'b0;
      ld_state_q      <= 1'b0;
      round_en_q      <= 1'b0;
      last_round_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      nr_q            <= nr_d;
      len_q           <= len_d;
      kexp_cnt_q      <= kexp_cnt_d;
      cache_valid_q   <= cache_valid_d;
      cache_len_q     <= cache_len_d;
      blk_cnt_q       <= blk_cnt_d;
      round_idx_q     <= round_idx_d;
      req_ready_q     <= req_ready_d;
      key_exp_start_q <= key_exp_start_d;
      ld_state_q      <= ld_state_d;
      round_en_q      <= round_en_d;
      last_round_q    <= last_round_d;
      out_valid_q     <= out_valid_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign key_exp_start = key_exp_start_q;
  assign ld_state      = ld_state_q;
  assign round_en      = round_en_q;
  assign round_idx     = round_idx_q;
  assign last_round    = last_round_q;
  assign out_valid     = out_valid_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a block-level model (key cache, Nr, handshake
// count) predicts the strobe trace every cycle; stimulus is partly random.
module tb_aes_round_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [1:0]       key_len;
  logic             key_reuse, abort;
  logic             key_exp_start, key_exp_done;
  logic             ld_state, round_en, last_round;
  logic [3:0]       round_idx;
  logic             out_valid, out_ready, err, busy;
  logic [CNT_W-1:0] blk_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: key cache and completed-block count
  bit m_cache_valid = 1'b0;
  int m_cache_len   = 0;
  int m_blk_cnt     = 0;

  aes_round_sequencer #(.KEXP_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .key_len(key_len), .key_reuse(key_reuse), .abort(abort),
    .key_exp_start(key_exp_start), .key_exp_done(key_exp_done),
    .ld_state(ld_state), .round_en(round_en), .round_idx(round_idx),
    .last_round(last_round), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Layout: {kes, ld, ren, last, idx[3:0], ov, busy, rr, err}
  function automatic logic [11:0] pk(input bit kes, input bit ld, input bit ren,
                                     input bit last, input int idx, input bit ov,
                                     input bit bsy, input bit rr, input bit er);
    return {kes, ld, ren, last, 4'(idx), ov, bsy, rr, er};
  endfunction

  function automatic logic [11:0] sample();
    return {key_exp_start, ld_state, round_en, last_round, round_idx,
            out_valid, busy, req_ready, err};
  endfunction

  localparam logic [11:0] IDLE_V = 12'b0000_0000_0010;

  // Runs one request from the IDLE negedge; abort indices are -1 when unused.
  task automatic do_block(input string nm, input int len, input bit reuse,
                          input int done_delay, input int out_wait,
                          input int kexp_abort, input int abort_at);
    int nr;
    bit kexp, aborted;
    logic [11:0] obs, exp;
    nr      = 10 + 2 * len;
    kexp    = !(reuse && m_cache_valid && m_cache_len == len);
    aborted = 1'b0;
    obs = sample();
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++;
      $display("[TB] FAIL %s idle_before: got %b expected %b", nm, obs, IDLE_V);
    end
    req_valid = 1'b1; key_len = 2'(len); key_reuse = reuse;
    @(negedge clk);
    req_valid = 1'b0;
    key_len   = 2'($urandom_range(0, 3));
    key_reuse = 1'($urandom_range(0, 1));
    if (kexp) begin
      for (int c = 0; c <= done_delay; c++) begin
        key_exp_done = (c == done_delay);
        obs = sample();
        exp = pk(c == 0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("[TB] FAIL %s kexp c=%0d: got %b expected %b", nm, c, obs, exp);
        end
        if (c == kexp_abort) begin abort = 1'b1; aborted = 1'b1; end
        @(negedge clk);
        abort = 1'b0;
        if (aborted) break;
      end
      key_exp_done = 1'b0;
      if (aborted) m_cache_valid = 1'b0;
      else begin m_cache_valid = 1'b1; m_cache_len = len; end
    end
    if (!aborted) begin
      for (int t = 0; t <= nr + 1 + out_wait; t++) begin
        obs = sample();
        if (t <= nr) begin
          exp = pk(0, t == 0, t > 0, t == nr, t, 0, 1, 0, 0);
          out_ready = 1'($urandom_range(0, 1));
        end else begin
          exp = pk(0, 0, 0, 0, 0, 1, 1, 0, 0);
          out_ready = (t == nr + 1 + out_wait);
        end
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("[TB] FAIL %s step t=%0d: got %b expected %b", nm, t, obs, exp);
        end
        if (t == abort_at) begin abort = 1'b1; out_ready = 1'b0; aborted = 1'b1; end
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        if (aborted) break;
      end
      if (!aborted) m_blk_cnt++;
    end
    obs = sample();
    n_checks++;
    if (obs !== IDLE_V || blk_cnt !== CNT_W'(m_blk_cnt)) begin
      n_fail++;
      $display("[TB] FAIL %s idle_after: got %b cnt=%0d expected %b cnt=%0d",
               nm, obs, blk_cnt, IDLE_V, m_blk_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; key_len = 2'd0; key_reuse = 1'b0; abort = 1'b0;
    key_exp_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sample() !== IDLE_V || blk_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b cnt=%0d expected %b cnt=0", sample(), blk_cnt, IDLE_V);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sample() !== IDLE_V || blk_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got %b cnt=%0d expected %b cnt=0", sample(), blk_cnt, IDLE_V);
    end
  endtask

  task automatic test_basic();
    do_block("basic128", 0, 0, 5, 2, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_block("b2b_exp256", 2, 0, 3, 0, -1, -1);
    do_block("b2b_reuse256_a", 2, 1, 0, 0, -1, -1);
    do_block("b2b_reuse256_b", 2, 1, 0, 1, -1, -1);
  endtask

  task automatic test_cache_mismatch();
    do_block("mismatch192", 1, 1, 4, 1, -1, -1);
  endtask

  task automatic test_illegal();
    req_valid = 1'b1; key_len = 2'd3; key_reuse = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (sample() !== pk(0, 0, 0, 0, 0, 0, 0, 1, 1)) begin
      n_fail++;
      $display("[TB] FAIL illegal_err: got %b expected %b", sample(), pk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    end
    @(negedge clk);
    n_checks++;
    if (sample() !== IDLE_V) begin
      n_fail++;
      $display("[TB] FAIL illegal_after: got %b expected %b", sample(), IDLE_V);
    end
  endtask

  task automatic test_timeout();
    logic [11:0] exp;
    req_valid = 1'b1; key_len = 2'd0; key_reuse = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      exp = pk(c == 0, 0, 0, 0, 0, 0, 1, 0, 0);
      n_checks++;
      if (sample() !== exp) begin
        n_fail++;
        $display("[TB] FAIL timeout_wait c=%0d: got %b expected %b", c, sample(), exp);
      end
      @(negedge clk);
    end
    exp = pk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_checks++;
    if (sample() !== exp) begin
      n_fail++;
      $display("[TB] FAIL timeout_err: got %b expected %b", sample(), exp);
    end
    m_cache_valid = 1'b0;
    @(negedge clk);
    do_block("timeout_reexpand", 0, 1, 2, 0, -1, -1);
  endtask

  task automatic test_abort();
    int ov_seen;
    req_valid = 1'b1; abort = 1'b1; key_len = 2'd0; key_reuse = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    n_checks++;
    if (sample() !== IDLE_V) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: got %b expected %b", sample(), IDLE_V);
    end
    do_block("abort_round5", m_cache_len, 1, 0, 0, -1, 5);
    do_block("abort_done", m_cache_len, 1, 0, 6, -1, 10 + 2 * m_cache_len + 3);
    ov_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b0) ov_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (ov_seen != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_out_valid: got %0d cycles expected 0", ov_seen);
    end
    do_block("abort_kexp", 1, 0, 10, 0, 3, -1);
    do_block("after_abort_kexp", 1, 1, 1, 0, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      do_block("random", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), -1, -1);
    end
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1; key_len = 2'd0; key_reuse = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; key_exp_done = 1'b1;
    @(negedge clk);
    key_exp_done = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (round_en !== 1'b1 || round_idx !== 4'd4) begin
      n_fail++;
      $display("[TB] FAIL rst_pre_round: got en=%b idx=%0d expected en=1 idx=4", round_en, round_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sample() !== IDLE_V || blk_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_async_clear: got %b cnt=%0d expected %b cnt=0", sample(), blk_cnt, IDLE_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cache_valid = 1'b0;
    m_blk_cnt = 0;
    @(negedge clk);
    do_block("after_reset_reexpand", 0, 1, 1, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cache_mismatch();
    test_illegal();
    test_timeout();
    test_abort();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
